// File: rtl/down_counter_311_if.sv
// Control/status bundle for down_counter_311. The master drives the controls
// and the slave (the counter) drives the registered status outputs.
interface down_counter_311_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_311;
  logic [WIDTH-1:0] load_val_311;
  logic             start_311;
  logic             stop_311;
  logic             auto_reload_311;
  logic [WIDTH-1:0] count_311;
  logic             tc_311;
  logic             busy_311;
  logic             done_311;

  modport master (
    output load_311, load_val_311, start_311, stop_311, auto_reload_311,
    input  count_311, tc_311, busy_311, done_311
  );

  modport slave (
    input  load_311, load_val_311, start_311, stop_311, auto_reload_311,
    output count_311, tc_311, busy_311, done_311
  );
endinterface

// File: rtl/down_counter_311.sv
// Loadable down counter/timer with pause/resume and auto-reload, falling-edge clocked.
// Optional prescaler enabled by defining DOWN_COUNTER_PRESCALE_EN.
module down_counter_311 #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic              clk_311,
  input  logic              reset_n_311,
  down_counter_311_if.slave ctr
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int unsigned PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0] presc_q, presc_d;

  assign tick = (presc_q == PS_W'(PRESCALE - 1));

  // Anything other than a counting RUN edge (load, stop, non-RUN state) clears
  // the prescaler, so every entry to RUN starts a fresh prescale period.
  always_comb begin
    presc_d = '0;
    if (state_q == RUN && !ctr.load_311 && !ctr.stop_311) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(negedge clk_311 or negedge reset_n_311) begin
    if (!reset_n_311) presc_q <= '0;
    else              presc_q <= presc_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (ctr.load_311) begin
      count_d  = ctr.load_val_311;
      reload_d = ctr.load_val_311;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ctr.stop_311 && ctr.start_311) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              tc_d    = 1'b1;
            end
          end
        end
        RUN: begin
          if (ctr.stop_311) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Terminal edge: reload in periodic mode so count never reads 0.
              tc_d = (count_q == WIDTH'(1));
              if (ctr.auto_reload_311 && reload_q != '0 && count_q == WIDTH'(1)) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end
          end
        end
        PAUSE: begin
          if (!ctr.stop_311 && ctr.start_311) state_d = RUN;
        end
        DONE: begin
          if (!ctr.stop_311 && ctr.start_311) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              state_d = RUN;
            end else begin
              tc_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(negedge clk_311 or negedge reset_n_311) begin
    // NOTE: registers use non-blocking assignments so all of them update
    // together from the values sampled at the same edge.
    if (!reset_n_311) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ctr.count_311 = count_q;
  assign ctr.tc_311    = tc_q;
  assign ctr.busy_311  = busy_q;
  assign ctr.done_311  = done_q;

endmodule
